// File: rtl/dm_ctrl.sv
// dm_ctrl: byte-addressable data memory with byte/half/word access,
// sign/zero-extended loads, alignment/range checks and a wait-state
// req/ready handshake. One access is in flight at a time.
module dm_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sext_q, sext_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                cur_we;
    logic [1:0]          cur_size;
    logic                cur_sext;
    logic [ADDR_W-1:0]   cur_addr;
    logic [31:0]         cur_wdata;
    logic                cur_bad;
    logic                commit;
    logic [IDX_W-1:0]    mem_idx;
    logic [3:0]          lane_en;
    logic [31:0]         wr_word;
    logic [31:0]         rd_word;

    logic [31:0] mem [DEPTH];

    // Misaligned, illegal size or word index beyond the array.
    function automatic logic req_bad(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        logic [31:0] widx;
        widx = '0;
        widx[ADDR_W-3:0] = a[ADDR_W-1:2];
        return (sz == 2'b11) ||
               (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00) ||
               (widx >= 32'(DEPTH));
    endfunction

    // Lane/half selection and extension of a loaded word.
    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return {{24{sx & b[7]}}, b};
            2'b01:   return {{16{sx & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Active request: live inputs while IDLE, latched copy afterwards.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we = we; cur_size = size; cur_sext = sext; cur_addr = addr; cur_wdata = wdata;
        end else begin
            cur_we = we_q; cur_size = size_q; cur_sext = sext_q; cur_addr = addr_q; cur_wdata = wdata_q;
        end
        cur_bad = req_bad(cur_size, cur_addr);
        commit  = (state_q == S_IDLE && req && !cur_bad && WAIT_STATES == 0) ||
                  (state_q == S_WAIT && cnt_q == 4'd1);
        mem_idx = cur_addr[IDX_W+1:2];
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        lane_en = 4'b0000;
        wr_word = cur_wdata;
        case (cur_size)
            2'b00: begin
                lane_en[cur_addr[1:0]] = 1'b1;
                wr_word = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                lane_en = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{cur_wdata[15:0]}};
            end
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    // Array read port and load-result update at the commit edge.
    always_comb begin
        rd_word = mem[mem_idx];
        rdata_d = rdata_q;
        if (commit && !cur_we) begin
            rdata_d = load_fmt(rd_word, cur_size, cur_sext, cur_addr[1:0]);
        end
    end

    // Next-state, request latch and response pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d = we; size_d = size; sext_d = sext; addr_d = addr; wdata_d = wdata;
                    if (cur_bad) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset drops any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (commit && cur_we && lane_en[k]) begin
                mem[mem_idx][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: one zero-wait instance (DEPTH=512) and one
// three-wait-state instance. Expected responses are queued at issue time
// and a negedge monitor compares them against each ready pulse.
module tb_dm_ctrl;

    typedef struct packed {
        logic        e;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req3 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, err0, err3, busy0, busy3;

    int   total = 0;
    int   bad   = 0;
    int   rdy3_cnt = 0;
    exp_t q0[$];
    exp_t q3[$];
    logic [31:0] last0 = '0, last3 = '0;

    always #5 clk = ~clk;

    dm_ctrl #(.DEPTH(512), .ADDR_W(12), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
    );

    dm_ctrl #(.DEPTH(1024), .ADDR_W(12), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3), .busy(busy3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    // Monitor: every ready pulse pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ready0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL u0 unexpected ready: got 1, expected 0");
                end else begin
                    e = q0.pop_front();
                    chk("u0 err", {31'b0, err0}, {31'b0, e.e});
                    chk("u0 rdata", rdata0, e.d);
                end
            end else if (err0) begin
                total++; bad++;
                $display("FAIL u0 err without ready: got 1, expected 0");
            end
            if (ready3) begin
                rdy3_cnt++;
                if (q3.size() == 0) begin
                    total++; bad++;
                    $display("FAIL u3 unexpected ready: got 1, expected 0");
                end else begin
                    e = q3.pop_front();
                    chk("u3 err", {31'b0, err3}, {31'b0, e.e});
                    chk("u3 rdata", rdata3, e.d);
                end
            end else if (err3) begin
                total++; bad++;
                $display("FAIL u3 err without ready: got 1, expected 0");
            end
        end
    end

    // One access on instance inst (0 or 3); checks latency and busy length.
    task automatic acc(input int inst, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [11:0] a, input logic [31:0] wd, input logic e,
                       input logic [31:0] rd, input string nm);
        int n, b, ws;
        logic rs, bs;
        ws = (inst == 0) ? 0 : 3;
        @(negedge clk);
        we = w; size = sz; sext = sx; addr = a; wdata = wd;
        if (inst == 0) begin
            if (!w && !e) last0 = rd;
            q0.push_back('{e: e, d: last0});
            req0 = 1'b1;
        end else begin
            if (!w && !e) last3 = rd;
            q3.push_back('{e: e, d: last3});
            req3 = 1'b1;
        end
        @(posedge clk);
        #1 req0 = 1'b0; req3 = 1'b0;
        n = 0; b = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            rs = (inst == 0) ? ready0 : ready3;
            bs = (inst == 0) ? busy0 : busy3;
            if (bs) b++;
            if (rs) break;
        end
        chk({nm, " latency"}, 32'(n), 32'(ws + 1));
        chk({nm, " busy cycles"}, 32'(b), 32'(ws + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, first, c0;
        logic [11:0] bb_addr [4];
        logic [31:0] bb_exp [4];
        bb_addr = '{12'h060, 12'h040, 12'h060, 12'h040};
        bb_exp  = '{32'h55AA55AA, 32'h0, 32'h55AA55AA, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst ready0", {31'b0, ready0}, 0);
        chk("rst err0",   {31'b0, err0},   0);
        chk("rst busy0",  {31'b0, busy0},  0);
        chk("rst rdata0", rdata0, 0);
        chk("rst ready3", {31'b0, ready3}, 0);
        chk("rst err3",   {31'b0, err3},   0);
        chk("rst busy3",  {31'b0, busy3},  0);
        chk("rst rdata3", rdata3, 0);

        // zero-wait instance: word, byte and half traffic
        acc(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 0, 0, "sw 010");
        acc(0, 0, 2'b10, 0, 12'h010, 0, 0, 32'hDEADBEEF, "lw 010");
        acc(0, 1, 2'b00, 0, 12'h020, 32'hAABBCC11, 0, 0, "sb 020");
        acc(0, 1, 2'b00, 0, 12'h021, 32'hAABBCC22, 0, 0, "sb 021");
        acc(0, 1, 2'b00, 0, 12'h022, 32'hAABBCC33, 0, 0, "sb 022");
        acc(0, 1, 2'b00, 0, 12'h023, 32'hAABBCC84, 0, 0, "sb 023");
        acc(0, 0, 2'b10, 0, 12'h020, 0, 0, 32'h84332211, "lw 020");
        acc(0, 0, 2'b00, 1, 12'h023, 0, 0, 32'hFFFFFF84, "lb 023");
        acc(0, 0, 2'b00, 0, 12'h023, 0, 0, 32'h00000084, "lbu 023");
        acc(0, 0, 2'b01, 1, 12'h022, 0, 0, 32'hFFFF8433, "lh 022");
        acc(0, 0, 2'b01, 0, 12'h020, 0, 0, 32'h00002211, "lhu 020");
        acc(0, 0, 2'b10, 0, 12'h002, 0, 1, 0, "lw 002 misaligned");
        acc(0, 1, 2'b01, 0, 12'h021, 32'h0000FFFF, 1, 0, "sh 021 misaligned");
        acc(0, 0, 2'b10, 0, 12'h020, 0, 0, 32'h84332211, "lw 020 after bad sh");
        acc(0, 0, 2'b11, 0, 12'h000, 0, 1, 0, "size 11");
        acc(0, 0, 2'b10, 0, 12'h800, 0, 1, 0, "lw 800 range");
        acc(0, 1, 2'b10, 0, 12'h800, 32'h12345678, 1, 0, "sw 800 range");
        acc(0, 1, 2'b01, 0, 12'h022, 32'h1234BEEF, 0, 0, "sh 022");
        acc(0, 0, 2'b10, 0, 12'h020, 0, 0, 32'hBEEF2211, "lw 020 after sh");
        acc(0, 1, 2'b10, 0, 12'h7FC, 32'h0BADF00D, 0, 0, "sw 7fc last");
        acc(0, 0, 2'b10, 0, 12'h7FC, 0, 0, 32'h0BADF00D, "lw 7fc last");
        acc(0, 0, 2'b00, 1, 12'h7FD, 0, 0, 32'hFFFFFFF0, "lb 7fd");

        // three-wait-state instance
        acc(3, 1, 2'b10, 0, 12'h064, 32'h0, 0, 0, "w3 sw 064");
        acc(3, 1, 2'b10, 0, 12'h040, 32'h0, 0, 0, "w3 sw 040");

        // store with req pulses during WAIT and RESP that must be ignored
        @(negedge clk);
        we = 1; size = 2'b10; sext = 0; addr = 12'h060; wdata = 32'h55AA55AA;
        q3.push_back('{e: 1'b0, d: last3});
        req3 = 1'b1;
        c0 = rdy3_cnt;
        @(posedge clk);
        #1 req3 = 1'b0;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready3 && first == 0) first = k;
            if (k == 1) begin
                we = 1; addr = 12'h064; wdata = 32'h99999999; req3 = 1'b1;
            end
            if (k == 2) req3 = 1'b0;
            if (k == 4) req3 = 1'b1;
            if (k == 5) req3 = 1'b0;
        end
        chk("w3 pulse latency", 32'(first), 32'd4);
        chk("w3 ready count", 32'(rdy3_cnt - c0), 32'd1);
        acc(3, 0, 2'b10, 0, 12'h064, 0, 0, 32'h0, "w3 lw 064 untouched");
        acc(3, 0, 2'b10, 0, 12'h060, 0, 0, 32'h55AA55AA, "w3 lw 060");

        // async reset in the middle of a waited store
        @(negedge clk);
        we = 1; size = 2'b10; addr = 12'h040; wdata = 32'hCAFEF00D;
        req3 = 1'b1;
        @(posedge clk);
        #1 req3 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        q3.delete();
        #1;
        chk("mid rst busy3",  {31'b0, busy3},  0);
        chk("mid rst ready3", {31'b0, ready3}, 0);
        chk("mid rst err3",   {31'b0, err3},   0);
        chk("mid rst rdata3", rdata3, 0);
        @(negedge clk) rst = 1'b0;
        last0 = '0; last3 = '0;
        acc(3, 0, 2'b10, 0, 12'h040, 0, 0, 32'h0, "w3 lw 040 after rst");

        // back-to-back with req held high, alternating addresses
        @(negedge clk);
        we = 0; size = 2'b10; sext = 0; addr = bb_addr[0];
        for (int i = 0; i < 4; i++) q3.push_back('{e: 1'b0, d: bb_exp[i]});
        req3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                n++;
                if (ready3) break;
            end
            chk("b2b spacing", 32'(n), (i == 0) ? 32'd4 : 32'd5);
            if (i < 3) addr = bb_addr[i + 1];
            else req3 = 1'b0;
        end

        repeat (8) @(negedge clk);
        chk("q0 drained", 32'(q0.size()), 0);
        chk("q3 drained", 32'(q3.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
Parametrised data-memory block for the single/multi-cycle CPU datapath, successor to the fixed 4 KB word-only data memory. Adds byte/halfword/word stores with byte lanes, sign/zero-extended sub-word loads, alignment and range checking, and a configurable wait-state req/ready handshake for stall control. Sits between the EX/MEM stage and the memory array; the stall unit keys off busy/ready.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; must satisfy DEPTH <= 2^(ADDR_W-2).
ADDR_W, 12, byte-address width.
WAIT_STATES, 0, extra cycles before an access commits; legal range 0..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-high.
req  input  1  access request; sampled only in IDLE.
we  input  1  1 = store, 0 = load; sampled with req.
size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
addr  input  ADDR_W  byte address.
wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
rdata  output  32  load result, extended to 32 bits.
ready  output  1  one-cycle completion pulse.
err  output  1  one-cycle error pulse, coincident with ready.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any state): state = IDLE; ready = 0, err = 0, busy = 0, rdata = 0; wait counter = 0; any latched, uncommitted store is discarded. The array is not cleared by reset. Array contents are zero at time 0.
- States: IDLE, WAIT, RESP.
- IDLE, req = 1 at edge E0:
  - Latch we, size, sext, addr, wdata.
  - Run checks on the latched request.
  - If an error is detected: go to RESP with err pending. No array write occurs.
  - Else if WAIT_STATES = 0: commit the access at E0 and go to RESP.
  - Else: load counter = WAIT_STATES and go to WAIT.
- WAIT: counter decrements each edge. On the edge where counter = 1, commit the access and go to RESP.
- RESP: lasts exactly one cycle. ready = 1; err = 1 if the request failed. Next edge returns to IDLE.
- Latency: ready is high in cycle E0 + WAIT_STATES + 1. A req presented while in WAIT or RESP is ignored, so the requester must hold or re-present req in IDLE. Peak throughput is one access per WAIT_STATES + 2 cycles.
- Error conditions:
  - size = 11.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 00.
  - Word index addr[ADDR_W-1:2] >= DEPTH.
- Byte lanes are little-endian: lane k = bits [8k+7:8k].
- Store by size:
  - Byte: writes wdata[7:0] to lane addr[1:0]; other lanes are unchanged.
  - Half: writes wdata[15:0] to lanes {2*addr[1]+1, 2*addr[1]}.
  - Word: writes the full word.
- Load by size:
  - Byte: selects lane addr[1:0], then extends per sext.
  - Half: selects the half at addr[1], then extends per sext.
  - Word: sext is ignored.
- rdata is registered at the commit edge. It holds its value until the next successful load. Stores and errored requests leave rdata unchanged.
- ready and err are registered outputs with no combinational path from the inputs.

Test Plan:
- Reset, then WAIT_STATES=0: word store 0xDEADBEEF @0x010, then word load @0x010 -> ready one cycle after each req edge; rdata = 0xDEADBEEF; err = 0; busy high for exactly 1 cycle per access.
- Byte stores 0x11, 0x22, 0x33, 0x84 to @0x020..0x023, then word load @0x020 -> 0x84332211. Then:
  - lb @0x023 -> 0xFFFFFF84.
  - lbu @0x023 -> 0x00000084.
  - lh @0x022 -> 0xFFFF8433.
  - lhu @0x020 -> 0x00002211.
- Errors:
  - Word load @0x002 -> err = ready = 1, rdata unchanged.
  - Half store @0x021 -> err, memory word unchanged.
  - size = 11 -> err.
  - With DEPTH = 512: word access @0x800 -> err.
- WAIT_STATES=3: req at E0 -> busy for 4 cycles, ready at E0+4; req pulses during busy are ignored and cause no second access.
- Async reset asserted mid-WAIT on a store of 0xCAFEF00D @0x040 -> outputs 0 immediately; a subsequent load @0x040 returns the old value 0x00000000.
- Back-to-back: req held high continuously with alternating addresses -> exactly one access per WAIT_STATES + 2 cycles; each ready carries the matching rdata.
